btn_pulse_bank: RTL and testbench

//  N-channel push-button front end: synchronises raw buttons, debounces each channel

---
 rtl/btn_pulse_bank.sv | 177 +++++++++++++++++
 tb/tb_btn_pulse_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_bank.sv
// btn_pulse_bank: N-channel push-button front end.
// Each raw button is passed through a 2-FF synchroniser and debounced against
// a shared ms tick. The block emits a one-cycle pulse on the debounced edge
// that edge_mode selects.
// Optional feature: define BTN_AUTOREPEAT_EN to build per-channel hold counters
// that issue auto-repeat pulses while a button stays pressed.

module btn_pulse_lane #(
   parameter int DB_TICKS   = 20
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int REP_DELAY  = 500,
   parameter int REP_PERIOD = 100
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_raw,
   input  logic [1:0] edge_mode,
   output logic       level,
   output logic       pulse
);

   localparam int DW = $clog2(DB_TICKS + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);

   logic          sync_q1, sync_q2;
   logic          stable, stable_d;
   logic [DW-1:0] db_cnt;
   logic          edge_evt, rep_evt, rep_mode;

   // two-flop synchroniser; the raw button is never used before sync_q2
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   // debounce: a differing input must persist across DB_TICKS ticks; any bounce restarts it
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= 1'b0;
         db_cnt <= '0;
      end else if (sync_q2 == stable) begin
         db_cnt <= '0;
      end else if (tick) begin
         if (db_cnt == DB_LAST) begin
            stable <= sync_q2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // edge selection against the previous stable level
   always_comb begin
      edge_evt = 1'b0;
      rep_mode = (edge_mode == 2'b00) || (edge_mode == 2'b10);
      case (edge_mode)
         2'b00:   edge_evt = stable & ~stable_d;
         2'b01:   edge_evt = ~stable & stable_d;
         2'b10:   edge_evt = stable ^ stable_d;
         default: edge_evt = 1'b0;
      endcase
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int HW = $clog2(REP_DELAY + REP_PERIOD + 1);
   localparam logic [HW-1:0] REP_FIRST = HW'(REP_DELAY);
   localparam logic [HW-1:0] REP_WRAP  = HW'(REP_DELAY + REP_PERIOD);

   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          rep_hit, rep_pend;

   // next hold value and whether this tick lands on a repeat point
   always_comb begin
      hold_nxt = hold_cnt + 1'b1;
      rep_hit  = tick & stable & rep_mode &
                 ((hold_nxt == REP_FIRST) || (hold_nxt == REP_WRAP));
   end

   // hold counter in ticks; folds back to REP_DELAY after each period so it never wraps
   always_ff @(posedge clk) begin
      if (rst || !stable || !rep_mode) begin
         hold_cnt <= '0;
         rep_pend <= 1'b0;
      end else begin
         rep_pend <= rep_hit;
         if (tick)
            hold_cnt <= (hold_nxt == REP_WRAP) ? REP_FIRST : hold_nxt;
      end
   end

   // a release landing on a repeat point suppresses the repeat
   assign rep_evt = rep_pend & stable & rep_mode;
`else
   assign rep_evt = 1'b0;
`endif

   // registered pulse, one cycle after the stable level moves
   always_ff @(posedge clk) begin
      if (rst) begin
         stable_d <= 1'b0;
         pulse    <= 1'b0;
      end else begin
         stable_d <= stable;
         pulse    <= edge_evt | rep_evt;
      end
   end

   assign level = stable;

endmodule

module btn_pulse_bank #(
   parameter int N          = 4,
   parameter int TICK_DIV   = 100000,
   parameter int DB_TICKS   = 20,
   parameter int REP_DELAY  = 500,
   parameter int REP_PERIOD = 100
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn_in,
   input  logic [1:0]   edge_mode,
   output logic [N-1:0] btn_level,
   output logic [N-1:0] pulse
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;

   // reject configurations the lanes cannot implement
   if (N < 1 || N > 16 || TICK_DIV < 2 || DB_TICKS < 1 ||
       REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_cfg
      $error("btn_pulse_bank: parameter out of range");
   end

   // shared debounce tick: free-running 0..TICK_DIV-1
   always_ff @(posedge clk) begin
      if (rst || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick = (tick_cnt == TICK_LAST);

   for (genvar i = 0; i < N; i++) begin : g_lane
      btn_pulse_lane #(
         .DB_TICKS   (DB_TICKS)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .REP_DELAY  (REP_DELAY),
         .REP_PERIOD (REP_PERIOD)
`endif
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .btn_raw   (btn_in[i]),
         .edge_mode (edge_mode),
         .level     (btn_level[i]),
         .pulse     (pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_pulse_bank.sv
// Bench for btn_pulse_bank with N=2, TICK_DIV=4, DB_TICKS=3, REP_DELAY=5, REP_PERIOD=2.
// Directed scenarios followed by a random phase; every cycle is compared against
// a cycle-indexed reference model, plus directed pulse-count checks.

module tb_btn_pulse_bank;

   localparam int N  = 2;
   localparam int TD = 4;
   localparam int DB = 3;
   localparam int RD = 5;
   localparam int RP = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic [1:0]   edge_mode = 2'b00;
   logic [N-1:0] btn_level;
   logic [N-1:0] pulse;

   int n_chk  = 0;
   int n_fail = 0;

   btn_pulse_bank #(
      .N(N), .TICK_DIV(TD), .DB_TICKS(DB), .REP_DELAY(RD), .REP_PERIOD(RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .edge_mode (edge_mode),
      .btn_level (btn_level),
      .pulse     (pulse)
   );

   always #5 clk = ~clk;

   // reference model state
   bit [N-1:0] m_s1, m_s2, m_stable, m_prev, m_pulse, m_rep;
   int         m_held [N];
   int         m_hold [N];
   int         m_since;

   // directed pulse counters
   int pcnt [N];
   int both_cnt;

   function automatic bit fires(input logic [1:0] m, input bit now, input bit was);
      case (m)
         2'b00:   return now && !was;
         2'b01:   return !now && was;
         2'b10:   return now != was;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic [N-1:0] b, input logic [1:0] m);
      bit tk, ok;
      if (r) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pulse = '0; m_rep = '0;
         for (int c = 0; c < N; c++) begin m_held[c] = 0; m_hold[c] = 0; end
         m_since = 0;
         return;
      end
      tk = (m_since % TD) == TD - 1;
      ok = (m == 2'b00) || (m == 2'b10);
      for (int c = 0; c < N; c++) begin
         m_pulse[c] = fires(m, m_stable[c], m_prev[c]);
`ifdef BTN_AUTOREPEAT_EN
         m_pulse[c] = m_pulse[c] | (m_rep[c] & m_stable[c] & ok);
         if (m_stable[c] && ok) begin
            if (tk) begin
               m_hold[c]++;
               m_rep[c] = (m_hold[c] == RD) || (m_hold[c] > RD && ((m_hold[c] - RD) % RP) == 0);
            end else begin
               m_rep[c] = 1'b0;
            end
         end else begin
            m_hold[c] = 0;
            m_rep[c]  = 1'b0;
         end
`endif
         m_prev[c] = m_stable[c];
         if (m_s2[c] == m_stable[c]) begin
            m_held[c] = 0;
         end else if (tk) begin
            m_held[c]++;
            if (m_held[c] == DB) begin
               m_stable[c] = m_s2[c];
               m_held[c]   = 0;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = b;
      m_since++;
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clr_cnt();
      for (int c = 0; c < N; c++) pcnt[c] = 0;
      both_cnt = 0;
   endtask

   // one clock: drive, let the edge happen, update model, check on the falling edge
   task automatic step(input logic r, input logic [N-1:0] b, input logic [1:0] m);
      rst = r; btn_in = b; edge_mode = m;
      @(posedge clk);
      model_edge(r, b, m);
      @(negedge clk);
      chk("level", btn_level, m_stable);
      chk("pulse", pulse, m_pulse);
      for (int c = 0; c < N; c++) if (pulse[c] === 1'b1) pcnt[c]++;
      if (pulse === 2'b11) both_cnt++;
   endtask

   task automatic run(input int n, input logic [N-1:0] b, input logic [1:0] m);
      for (int k = 0; k < n; k++) step(1'b0, b, m);
   endtask

   initial begin
      logic [N-1:0] rb;
      logic [1:0]   rm;
      bit           got;

      // 1: reset with both buttons held, then both rise together
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 2'b11, 2'b00);
         chk("rst_level", btn_level, 2'b00);
         chk("rst_pulse", pulse, 2'b00);
      end
      clr_cnt();
      run(2 + 3 * TD + 1, 2'b11, 2'b00);
      chk_int("t1_both_pulse", both_cnt, 1);
      run(24, 2'b00, 2'b00);
      clr_cnt();

      // 2: clean press on ch0, then release in rising mode
      run(24, 2'b01, 2'b00);
      chk_int("t2_press_pulses", pcnt[0], 1);
      chk("t2_level", btn_level, 2'b01);
      clr_cnt();
      run(24, 2'b00, 2'b00);
      chk_int("t2_release_pulses", pcnt[0], 0);

      // 3: bounce every 3 cycles, then hold
      clr_cnt();
      for (int k = 0; k < 40; k++) step(1'b0, {1'b0, 1'(((k / 3) % 2) == 0)}, 2'b00);
      chk_int("t3_bounce_pulses", pcnt[0], 0);
      run(24, 2'b01, 2'b00);
      chk_int("t3_hold_pulses", pcnt[0], 1);
      run(24, 2'b00, 2'b00);

      // 4: both-edges mode, then disabled mode on ch1
      clr_cnt();
      run(24, 2'b10, 2'b10);
      run(24, 2'b00, 2'b10);
      chk_int("t4_both_edges", pcnt[1], 2);
      clr_cnt();
      run(24, 2'b10, 2'b11);
      chk("t4_level_m11", btn_level, 2'b10);
      run(24, 2'b00, 2'b11);
      chk_int("t4_disabled", pcnt[1], 0);

      // 5: simultaneous press, then reset mid-debounce
      clr_cnt();
      run(24, 2'b11, 2'b00);
      chk_int("t5_same_cycle", both_cnt, 1);
      run(24, 2'b00, 2'b00);
      clr_cnt();
      run(8, 2'b11, 2'b00);
      step(1'b1, 2'b11, 2'b00);
      chk("t5_rst_pulse", pulse, 2'b00);
      run(12, 2'b11, 2'b00);
      chk_int("t5_no_early", pcnt[0] + pcnt[1], 0);
      run(3, 2'b11, 2'b00);
      chk_int("t5_restart", both_cnt, 1);
      run(24, 2'b00, 2'b00);

      // 6: long hold on ch0 for 12 ticks after acceptance
      clr_cnt();
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         step(1'b0, 2'b01, 2'b00);
         got = (pcnt[0] != 0);
      end
      chk_int("t6_accept", int'(got), 1);
      run(12 * TD, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
      chk_int("t6_repeat_count", pcnt[0], 5);
`else
      chk_int("t6_repeat_count", pcnt[0], 1);
`endif
      run(30, 2'b00, 2'b00);

      // random phase: held presses, bounces, mode changes and rare resets
      rb = '0;
      rm = 2'b00;
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 11) == 0) rb[c] = ~rb[c];
         if ($urandom_range(0, 59) == 0) rm = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 299) == 0), rb, rm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
